ex_data_fifo_wr_arb: RTL and testbench

//  Round-robin burst arbiter sharing the single write port of the ex_data FIFO between N_REQ producers.

---
 rtl/ex_data_fifo_wr_arb_pkg.sv | 15 +
 rtl/ex_data_fifo_wr_arb_if.sv | 36 +++
 rtl/ex_data_fifo_wr_arb_rr_pick.sv | 37 +++
 rtl/ex_data_fifo_wr_arb.sv | 102 ++++++++++
 tb/tb_ex_data_fifo_wr_arb.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_data_fifo_wr_arb_pkg.sv
// ex_data_pkg: shared types and helpers for the ex_data FIFO write arbiter.
//   state_t   : arbiter FSM state (IDLE waits for a grant, BURST owns the write port)
//   rr_idx_w  : width of a requester index for n requesters (at least 1 bit)
package ex_data_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int rr_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ex_data_fifo_wr_arb_if.sv
// ex_data_fifo_wr_arb_if: requester bundle plus FIFO write port of the arbiter.
//   req_valid/req_last/req_data : per-requester beat offer (data packed per requester)
//   req_ready                   : per-requester accept
//   fifo_wr_en/fifo_wr_data     : FIFO write port
//   fifo_wr_full/almost_full    : FIFO flags
//   owner/busy                  : grant status
// Modports: master = arbiter, slave = producers + FIFO side.
interface ex_data_fifo_wr_arb_if
    import ex_data_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
) ();
    localparam int IDX_W = rr_idx_w(N_REQ);

    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0]                 req_last;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                 req_ready;
    logic                             fifo_wr_en;
    logic [DATA_WIDTH-1:0]            fifo_wr_data;
    logic                             fifo_wr_full;
    logic                             fifo_almost_full;
    logic [IDX_W-1:0]                 owner;
    logic                             busy;

    modport master (
        input  req_valid, req_last, req_data, fifo_wr_full, fifo_almost_full,
        output req_ready, fifo_wr_en, fifo_wr_data, owner, busy
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_wr_full, fifo_almost_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, owner, busy
    );
endinterface

// File: rtl/ex_data_fifo_wr_arb_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   i_req   : request vector
//   i_ptr   : highest-priority index
//   o_idx   : first set index scanning i_ptr, i_ptr+1, ... modulo N_REQ
//   o_found : any request set
module rr_pick
    import ex_data_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = rr_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest hit to i_ptr wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[wrap_add(i_ptr, k)]) begin
                o_found = 1'b1;
                o_idx   = wrap_add(i_ptr, k);
            end
        end
    end

endmodule

// File: rtl/ex_data_fifo_wr_arb.sv
// ex_data_fifo_wr_arb: round-robin burst arbiter for the ex_data FIFO write port.
//   clk : FIFO write clock
//   rst : asynchronous reset, active-high
//   bus : requester beats in, FIFO write port out, owner/busy status
// A grant lasts until the owner's last beat or MAX_BURST accepted beats.
// One IDLE cycle separates bursts; the FIFO full flag stalls a burst,
// almost-full only blocks new grants.
module ex_data_fifo_wr_arb
    import ex_data_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ex_data_fifo_wr_arb_if.master  bus
);

    localparam int IDX_W = rr_idx_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_beat_cnt;

    logic [IDX_W-1:0] w_pick;
    logic             w_found;
    logic             w_grant;
    logic             w_accept;
    logic             w_burst_end;
    logic [IDX_W-1:0] w_owner_inc;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    assign w_grant  = (r_state == IDLE) && w_found && !bus.fifo_almost_full;
    assign w_accept = (r_state == BURST) && bus.req_valid[r_owner] && !bus.fifo_wr_full;
    // Last beat and burst cap on the same beat collapse into one end.
    assign w_burst_end = w_accept &&
                         (bus.req_last[r_owner] || (r_beat_cnt == CNT_W'(MAX_BURST - 1)));
    assign w_owner_inc = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; a burst with an idle owner simply holds.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant)     w_state_nxt = BURST;
            BURST:   if (w_burst_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Owner, round-robin pointer and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_grant) begin
                r_owner    <= w_pick;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (w_burst_end) r_rr_ptr <= w_owner_inc;
            end
        end
    end

    // Outputs: everything quiet outside BURST
    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = '0;
        bus.busy         = 1'b0;
        if (r_state == BURST) begin
            bus.busy               = 1'b1;
            bus.req_ready[r_owner] = !bus.fifo_wr_full;
            bus.fifo_wr_en         = w_accept;
            bus.fifo_wr_data       = bus.req_data[r_owner];
        end
    end

    assign bus.owner = r_owner;

endmodule

// File: tb/tb_ex_data_fifo_wr_arb.sv
// tb_ex_data_fifo_wr_arb: directed bench for the ex_data FIFO write arbiter.
// Producers are modelled as beat counters (remaining beats, packet length,
// sequence number); data = {requester, seq}. Every FIFO write is logged with
// owner and cycle and compared against hand-built expected tables.
module tb_ex_data_fifo_wr_arb;
    import ex_data_pkg::*;

    localparam int N_REQ = 4;
    localparam int DW    = 32;
    localparam int MAXB  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_data_fifo_wr_arb_if #(.N_REQ(N_REQ), .DATA_WIDTH(DW)) bus ();

    ex_data_fifo_wr_arb #(
        .N_REQ      (N_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk, n_pass, cyc;
    int rem [N_REQ];
    int plen[N_REQ];
    int pcnt[N_REQ];
    int seq [N_REQ];

    logic             s_en, s_busy;
    logic [DW-1:0]    s_data;
    logic [N_REQ-1:0] s_rdy, s_acc;
    logic [1:0]       s_own;

    int          lg_own[$];
    logic [31:0] lg_data[$];
    int          lg_cyc[$];
    int          exp_own[$];
    int          exp_seq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_valid[i] = (rem[i] > 0);
            bus.req_last[i]  = (rem[i] > 0) && (plen[i] != 0) && (pcnt[i] == plen[i] - 1);
            bus.req_data[i]  = {i[7:0], seq[i][23:0]};
        end
    endtask

    // One cycle: sample at negedge, advance producers just after posedge.
    task automatic tick();
        @(negedge clk);
        s_en   = bus.fifo_wr_en;
        s_data = bus.fifo_wr_data;
        s_busy = bus.busy;
        s_rdy  = bus.req_ready;
        s_own  = bus.owner;
        s_acc  = bus.req_valid & bus.req_ready;
        if (s_en) begin
            lg_own.push_back(int'(s_own));
            lg_data.push_back(s_data);
            lg_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N_REQ; i++) begin
            if (s_acc[i]) begin
                rem[i]--;
                seq[i]++;
                pcnt[i] = (plen[i] != 0 && pcnt[i] == plen[i] - 1) ? 0 : pcnt[i] + 1;
            end
        end
        drive();
    endtask

    function automatic bit alldone();
        for (int i = 0; i < N_REQ; i++) if (rem[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_log();
        lg_own.delete(); lg_data.delete(); lg_cyc.delete();
        exp_own.delete(); exp_seq.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.fifo_wr_full     = 1'b0;
        bus.fifo_almost_full = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            rem[i] = 0; plen[i] = 0; pcnt[i] = 0; seq[i] = 0;
        end
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    task automatic set_req(input int i, input int n, input int len);
        rem[i]  = n;
        plen[i] = len;
        drive();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        tick();
        n = 1;
        while (!(alldone() && !s_busy) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic exp_add(input int o, input int s0, input int n);
        for (int k = 0; k < n; k++) begin
            exp_own.push_back(o);
            exp_seq.push_back(s0 + k);
        end
    endtask

    task automatic cmp_log(input string tag);
        int n;
        chk({tag, "_count"}, 32'(lg_data.size()), 32'(exp_own.size()));
        n = (lg_data.size() < exp_own.size()) ? lg_data.size() : exp_own.size();
        for (int e = 0; e < n; e++) begin
            chk({tag, "_owner"}, 32'(lg_own[e]), 32'(exp_own[e]));
            chk({tag, "_data"}, lg_data[e], {exp_own[e][7:0], exp_seq[e][23:0]});
        end
    endtask

    initial begin
        int n;
        int c0;
        n_chk = 0; n_pass = 0; cyc = 0;
        bus.fifo_wr_full     = 1'b0;
        bus.fifo_almost_full = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            rem[i] = 0; plen[i] = 0; pcnt[i] = 0; seq[i] = 0;
        end
        drive();

        // Reset state, with a requester already valid
        set_req(0, 1, 1);
        @(posedge clk);
        #1;
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_en",    32'(bus.fifo_wr_en), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_data",  bus.fifo_wr_data, 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);

        // 1: single requester, 3 beats; grant costs one cycle
        do_reset();
        set_req(0, 3, 3);
        tick();
        chk("t1_idle", 32'({s_busy, s_en, s_rdy}), 32'd0);
        tick();
        chk("t1_grant", 32'({s_busy, s_own, s_en, s_rdy}), 32'({1'b1, 2'd0, 1'b1, 4'b0001}));
        tick();
        tick();
        tick();
        chk("t1_after", 32'({s_busy, s_en, s_own}), 32'd0);
        // rr_ptr now 1: req1 beats req0 to the next grant
        set_req(0, 1, 1);
        set_req(1, 1, 1);
        run_until_idle(20, "t1_done");
        exp_add(0, 0, 3);
        exp_add(1, 0, 1);
        exp_add(0, 3, 1);
        cmp_log("t1");
        chk("t1_lat", 32'(lg_cyc[0]), 32'd1);

        // 2: round robin, all four with two 2-beat packets
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 4, 2);
        run_until_idle(100, "t2_done");
        for (int b = 0; b < 8; b++) exp_add(b % 4, (b / 4) * 2, 2);
        cmp_log("t2");
        chk("t2_beat",   32'(lg_cyc[1] - lg_cyc[0]), 32'd1);
        chk("t2_bubble", 32'(lg_cyc[2] - lg_cyc[1]), 32'd2);

        // 3: burst cap, req1 40 beats without last, req3 one short packet
        do_reset();
        set_req(1, 40, 0);
        set_req(3, 2, 2);
        n = 0;
        while (!alldone() && n < 200) begin
            tick();
            n++;
        end
        chk("t3_done", 32'(n < 200), 32'd1);
        tick();
        chk("t3_hold", 32'({s_busy, s_own, s_en}), 32'({1'b1, 2'd1, 1'b0}));
        exp_add(1, 0, 16);
        exp_add(3, 0, 2);
        exp_add(1, 16, 24);
        cmp_log("t3");
        chk("t3_cap1", 32'(lg_cyc[16] - lg_cyc[15]), 32'd2);
        chk("t3_cap2", 32'(lg_cyc[34] - lg_cyc[33]), 32'd2);

        // 4: full for 5 cycles after 3 beats; cap still lands after 16 beats
        do_reset();
        set_req(2, 18, 18);
        n = 0;
        while (lg_data.size() < 3 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_start", 32'(n < 20), 32'd1);
        bus.fifo_wr_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_stall", 32'({s_busy, s_en, s_rdy}), 32'({1'b1, 1'b0, 4'b0000}));
        end
        bus.fifo_wr_full = 1'b0;
        run_until_idle(60, "t4_done");
        exp_add(2, 0, 18);
        cmp_log("t4");
        chk("t4_gap", 32'(lg_cyc[3] - lg_cyc[2]), 32'd6);
        chk("t4_cap", 32'(lg_cyc[16] - lg_cyc[15]), 32'd2);

        // 5: almost-full blocks grants only
        do_reset();
        bus.fifo_almost_full = 1'b1;
        set_req(2, 3, 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_block", 32'({s_busy, s_en}), 32'd0);
        end
        bus.fifo_almost_full = 1'b0;
        c0 = cyc;
        tick();
        tick();
        chk("t5_first", 32'({s_busy, s_en}), 32'b11);
        bus.fifo_almost_full = 1'b1;
        run_until_idle(20, "t5_done");
        chk("t5_lat",  32'(lg_cyc[0]), 32'(c0 + 1));
        chk("t5_cont", 32'(lg_cyc[2] - lg_cyc[0]), 32'd2);
        set_req(0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_block2", 32'({s_busy, s_en}), 32'd0);
        end
        bus.fifo_almost_full = 1'b0;
        run_until_idle(20, "t5_done2");
        exp_add(2, 0, 3);
        exp_add(0, 0, 1);
        cmp_log("t5");

        // 6: reset at beat 7 of a req3 burst, with rr_ptr moved to 1 first
        do_reset();
        set_req(0, 1, 1);
        run_until_idle(20, "t6_pre");
        clear_log();
        set_req(3, 20, 20);
        n = 0;
        while (lg_data.size() < 6 && n < 30) begin
            tick();
            n++;
        end
        chk("t6_start", 32'(n < 30), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_busy",  32'(bus.busy), 32'd0);
        chk("t6_en",    32'(bus.fifo_wr_en), 32'd0);
        chk("t6_ready", 32'(bus.req_ready), 32'd0);
        chk("t6_data",  bus.fifo_wr_data, 32'd0);
        chk("t6_owner", 32'(bus.owner), 32'd0);
        set_req(0, 1, 1);
        set_req(1, 1, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        run_until_idle(100, "t6_done");
        exp_add(0, 1, 1);
        exp_add(1, 0, 1);
        exp_add(3, 6, 14);
        cmp_log("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
